// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor with valid/ready handshake.
// The WIDTH-bit carry chain is cut into STAGES chunks of CHUNK bits; each
// stage adds one chunk, so a new operation can be accepted every cycle.
// Subtraction is a + ~b + 1: b is inverted on entry and op is the carry-in.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  // Per-stage pipeline registers. r_b holds the (possibly inverted) b'.
  logic             r_valid [STAGES];
  logic [WIDTH-1:0] r_a     [STAGES];
  logic [WIDTH-1:0] r_b     [STAGES];
  logic [WIDTH-1:0] r_sum   [STAGES];
  logic             r_carry [STAGES];
  logic             r_zero  [STAGES];
  logic             r_cmsb;

  // Per-stage inputs (from the ports for stage 0, else from the previous stage).
  logic             w_vin     [STAGES];
  logic [WIDTH-1:0] w_src_a   [STAGES];
  logic [WIDTH-1:0] w_src_b   [STAGES];
  logic [WIDTH-1:0] w_src_sum [STAGES];
  logic             w_cin     [STAGES];
  logic             w_zin     [STAGES];
  logic [CHUNK:0]   w_chunk   [STAGES];
  logic [WIDTH-1:0] w_sum_next[STAGES];
  logic             w_stall;
  logic             w_cmsb;

  // The whole pipeline freezes only when the result cannot leave.
  assign w_stall  = r_valid[LAST] & ~out_ready;
  assign in_ready = ~w_stall;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign w_vin[gi]     = in_valid & in_ready;
        assign w_src_a[gi]   = a;
        assign w_src_b[gi]   = b ^ {WIDTH{op}};
        assign w_src_sum[gi] = '0;
        assign w_cin[gi]     = op;
        assign w_zin[gi]     = 1'b1;
      end else begin : g_next
        assign w_vin[gi]     = r_valid[gi-1];
        assign w_src_a[gi]   = r_a[gi-1];
        assign w_src_b[gi]   = r_b[gi-1];
        assign w_src_sum[gi] = r_sum[gi-1];
        assign w_cin[gi]     = r_carry[gi-1];
        assign w_zin[gi]     = r_zero[gi-1];
      end

      // Chunk add with carry-out in the top bit.
      assign w_chunk[gi] = {1'b0, w_src_a[gi][gi*CHUNK +: CHUNK]}
                         + {1'b0, w_src_b[gi][gi*CHUNK +: CHUNK]}
                         + {{CHUNK{1'b0}}, w_cin[gi]};

      // Insert this chunk into the partial sum; lower chunks pass through.
      assign w_sum_next[gi] =
          (w_src_sum[gi] & ~(WIDTH'({CHUNK{1'b1}}) << (gi * CHUNK)))
        | (WIDTH'(w_chunk[gi][CHUNK-1:0]) << (gi * CHUNK));
    end
  endgenerate

  // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
  assign w_cmsb = w_src_a[LAST][WIDTH-1] ^ w_src_b[LAST][WIDTH-1]
                ^ w_sum_next[LAST][WIDTH-1];

  // Advance every stage together unless stalled; reset clears all state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_a[k]     <= '0;
        r_b[k]     <= '0;
        r_sum[k]   <= '0;
        r_carry[k] <= 1'b0;
        r_zero[k]  <= 1'b0;
      end
      r_cmsb <= 1'b0;
    end else if (!w_stall) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= w_vin[k];
        r_a[k]     <= w_src_a[k];
        r_b[k]     <= w_src_b[k];
        r_sum[k]   <= w_sum_next[k];
        r_carry[k] <= w_chunk[k][CHUNK];
        r_zero[k]  <= w_zin[k] & (w_chunk[k][CHUNK-1:0] == '0);
      end
      r_cmsb <= w_cmsb;
    end
  end

  assign out_valid = r_valid[LAST];
  assign sum       = r_sum[LAST];
  assign carryout  = r_carry[LAST];
  assign overflow  = r_cmsb ^ r_carry[LAST];
  assign zero      = r_zero[LAST];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Randomised and directed bench for pipelined_addsub (WIDTH=32, STAGES=4).
// Expected results come from a plain-arithmetic model and an in-order queue.
module tb_pipelined_addsub;

  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carryout;
  logic         overflow;
  logic         zero;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carryout(carryout), .overflow(overflow), .zero(zero)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
    logic         z;
    int unsigned  t_acc;
    int unsigned  st_acc;
  } exp_t;

  exp_t         exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int unsigned  cyc = 0;
  int unsigned  stall_cnt = 0;
  int           n_out = 0;
  logic         acc_flag = 1'b0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] held_sum;
  logic [2:0]   held_flags;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: unsigned result modulo 2^W, carry = no-borrow for subtract,
  // overflow = signed result out of range.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic o);
    exp_t        e;
    longint      sr;
    logic [W:0]  full;
    e.a = x; e.b = y; e.op = o;
    if (o) begin
      e.sum = x - y;
      e.co  = (x >= y);
      sr    = longint'($signed(x)) - longint'($signed(y));
    end else begin
      full  = {1'b0, x} + {1'b0, y};
      e.sum = full[W-1:0];
      e.co  = full[W];
      sr    = longint'($signed(x)) + longint'($signed(y));
    end
    e.ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.z  = (e.sum == '0);
    e.t_acc  = 0;
    e.st_acc = 0;
    return e;
  endfunction

  // One clock: observe just after the falling edge, then advance one cycle.
  task automatic tick();
    exp_t e;
    logic stall;
    #1;
    acc_flag = 1'b0;
    if (reset_n) begin
      stall = out_valid && !out_ready;
      check("in_ready", in_ready, !stall);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_sum", sum, held_sum);
        check("hold_flags", {carryout, overflow, zero}, held_flags);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          n_out++;
          $display("[tb] out #%0d a=%h b=%h op=%0d sum=%h co=%0d ov=%0d z=%0d",
                   n_out, e.a, e.b, e.op, sum, carryout, overflow, zero);
          check("sum", sum, e.sum);
          check("carryout", carryout, e.co);
          check("overflow", overflow, e.ov);
          check("zero", zero, e.z);
          check("latency", cyc - e.t_acc, S + stall_cnt - e.st_acc);
        end
      end
      if (in_valid && in_ready) begin
        e = model(a, b, op);
        e.t_acc  = cyc;
        e.st_acc = stall_cnt;
        exp_q.push_back(e);
        acc_flag = 1'b1;
      end
      if (stall) stall_cnt++;
      held_sum   = sum;
      held_flags = {carryout, overflow, zero};
      prev_stall = stall;
    end else begin
      exp_q.delete();
      prev_stall = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (exp_q.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic o);
    int n = 0;
    a = x; b = y; op = o; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    while (!acc_flag && n < 20) begin
      tick();
      n++;
    end
    check("accept_timeout", acc_flag, 1);
    drain();
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    tick();
    tick();
    reset_n = 1'b1;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);

    // Directed arithmetic and flag cases.
    do_op(32'd5, 32'd7, 1'b0);
    do_op(32'h7FFF_FFFF, 32'd1, 1'b0);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0);
    do_op(32'd3, 32'd5, 1'b1);
    do_op(32'h8000_0000, 32'd1, 1'b1);
    do_op(32'd9, 32'd9, 1'b1);
    do_op(32'h00FF_FFFF, 32'd1, 1'b0);
    do_op(32'h0000_FFFF, 32'd1, 1'b0);
    do_op(32'h0000_00FF, 32'd1, 1'b0);

    // Back-to-back stream of 8 ops with out_ready low for cycles 6..9.
    begin
      int sent = 0;
      int c = 0;
      in_valid = 1'b1;
      a = $urandom; b = $urandom; op = 1'($urandom_range(0, 1));
      while (sent < 8 && c < 40) begin
        out_ready = !(c >= 6 && c <= 9);
        tick();
        if (acc_flag) begin
          sent++;
          a = $urandom; b = $urandom; op = 1'($urandom_range(0, 1));
        end
        c++;
      end
      check("stream_sent", sent, 8);
      in_valid = 1'b0;
      while (c <= 9) begin
        out_ready = !(c >= 6 && c <= 9);
        tick();
        c++;
      end
      out_ready = 1'b1;
      drain();
    end

    // Reset while three results are in flight.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; op = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    reset_n  = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midreset_out_valid", out_valid, 0);
    for (int i = 0; i < 6; i++) tick();
    do_op($urandom, $urandom, 1'($urandom_range(0, 1)));

    // Random traffic with random backpressure.
    in_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!in_valid || acc_flag) begin
        a = rnd_operand(); b = rnd_operand(); op = 1'($urandom_range(0, 1));
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
